// File: rtl/sram_burst_controller_pkg.sv
// SRAM burst controller shared definitions.
// FSM encoding and legal configuration ranges.
package sram_burst_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam int DATA_W_MIN = 16;
  localparam int DATA_W_MAX = 64;
  localparam int WAIT_MIN   = 0;
  localparam int WAIT_MAX   = 7;

  function automatic bit legal_cfg(int dw, int wc);
    return (dw == 16 || dw == 32 || dw == 64) &&
           (wc >= WAIT_MIN) && (wc <= WAIT_MAX);
  endfunction

endpackage

// File: rtl/sram_burst_controller_beat_timer.sv
// Beat and wait counters for one SRAM burst.
// Counters idle at zero whenever the burst is not running.
module sram_beat_timer #(
  parameter int BEATS       = 2,
  parameter int WAIT_CYCLES = 0,
  parameter int BW          = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_run,
  output logic [BW-1:0] o_beat,
  output logic          o_last_cycle,
  output logic          o_last_beat
);

  localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [WW-1:0] r_wait;
  logic [BW-1:0] r_beat;

  assign o_beat       = r_beat;
  assign o_last_cycle = (r_wait == WW'(WAIT_CYCLES));
  assign o_last_beat  = (r_beat == BW'(BEATS - 1));

  // Advance wait counter each cycle, beat counter at end of each beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait <= '0;
      r_beat <= '0;
    end else if (!i_run) begin
      r_wait <= '0;
      r_beat <= '0;
    end else if (o_last_cycle) begin
      r_wait <= '0;
      r_beat <= o_last_beat ? '0 : r_beat + 1'b1;
    end else begin
      r_wait <= r_wait + 1'b1;
    end
  end

endmodule

// File: rtl/sram_burst_controller.sv
// Host-word to 16-bit asynchronous SRAM burst controller.
// One host access becomes BEATS SRAM cycles of WAIT_CYCLES+1 clocks.
module sram_burst_controller
  import sram_burst_controller_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         address,
  input  logic [DATA_W-1:0]   dataIn,
  input  logic [DATA_W/8-1:0] byteEn,
  inout  wire  [15:0]         SRAMData,
  output logic [SRAM_AW-1:0]  SRAMAddress,
  output logic                SRAMUB,
  output logic                SRAMLB,
  output logic                SRAMWE,
  output logic                SRAMOE,
  output logic                SRAMCE,
  output logic [DATA_W-1:0]   dataOut,
  output logic                dataValid,
  output logic                freeze
);

  localparam int BEATS  = DATA_W / 16;
  localparam int BE_W   = DATA_W / 8;
  localparam int LB     = (BEATS > 1) ? $clog2(BEATS) : 0;
  localparam int LBB    = $clog2(BE_W);
  localparam int WORD_W = SRAM_AW - LB;
  localparam int HI     = WORD_W + LBB - 1;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t              r_state;
  state_t              w_next;
  logic [WORD_W-1:0]   r_word;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_dout;
  logic [BE_W-1:0]     r_be;
  logic                r_wr;
  logic [BW-1:0]       w_beat;
  logic                w_last_cycle;
  logic                w_last_beat;
  logic                w_access;
  logic                w_drive;
  logic [BW+3:0]       w_bit;
  logic [BW:0]         w_lane;
  logic [15:0]         w_wslice;
  logic [1:0]          w_wlanes;
  logic [SRAM_AW-1:0]  w_addr;
  logic                w_unused_addr;

  assign w_access      = (r_state == S_ACCESS);
  assign w_bit         = {w_beat, 4'b0};
  assign w_lane        = {w_beat, 1'b0};
  assign w_wslice      = r_data[w_bit +: 16];
  assign w_wlanes      = r_be[w_lane +: 2];
  assign w_unused_addr = ^{address[31:HI+1], address[LBB-1:0]};

  sram_beat_timer #(
    .BEATS       (BEATS),
    .WAIT_CYCLES (WAIT_CYCLES),
    .BW          (BW)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_run        (w_access),
    .o_beat       (w_beat),
    .o_last_cycle (w_last_cycle),
    .o_last_beat  (w_last_beat)
  );

  if (BEATS == 1) begin : g_addr1
    assign w_addr = r_word;
  end else begin : g_addrn
    assign w_addr = {r_word, w_beat};
  end

  assign SRAMAddress = w_access ? w_addr : '0;
  assign SRAMData    = w_drive ? w_wslice : 'z;
  assign dataOut     = r_dout;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state; an all-zero write mask skips the SRAM entirely
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (write)     w_next = (byteEn == '0) ? S_DONE : S_ACCESS;
        else if (read) w_next = S_ACCESS;
      end
      S_ACCESS: if (w_last_cycle && w_last_beat) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // SRAM strobes and host handshake decoded from state and captured op
  always_comb begin
    freeze    = 1'b0;
    dataValid = 1'b0;
    SRAMCE    = 1'b1;
    SRAMWE    = 1'b1;
    SRAMOE    = 1'b1;
    SRAMUB    = 1'b1;
    SRAMLB    = 1'b1;
    w_drive   = 1'b0;
    unique case (r_state)
      S_IDLE: freeze = read | write;
      S_ACCESS: begin
        freeze = 1'b1;
        SRAMCE = 1'b0;
        if (r_wr) begin
          SRAMWE  = 1'b0;
          w_drive = 1'b1;
          SRAMLB  = ~w_wlanes[0];
          SRAMUB  = ~w_wlanes[1];
        end else begin
          SRAMOE = 1'b0;
          SRAMUB = 1'b0;
          SRAMLB = 1'b0;
        end
      end
      S_DONE:  dataValid = ~r_wr;
      default: ;
    endcase
  end

  // Latch the request; write wins when both are asserted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word <= '0;
      r_data <= '0;
      r_be   <= '0;
      r_wr   <= 1'b0;
    end else if (r_state == S_IDLE && (read | write)) begin
      r_word <= address[HI:LBB];
      r_data <= dataIn;
      r_be   <= byteEn;
      r_wr   <= write;
    end
  end

  // Sample the bus into the beat's slice on its last cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
    end else if (w_access && !r_wr && w_last_cycle) begin
      r_dout[w_bit +: 16] <= SRAMData;
    end
  end

endmodule
